// File: rtl/regfile_mp_pkg.sv
// Shared datapath defaults and helpers for the multi-port register file.
// Optional read bypass is enabled by defining REGFILE_BYPASS_EN.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef RA_LEN
`define RA_LEN 5
`endif

package regfile_mp_pkg;

   localparam int unsigned DEF_WORD_LEN = `WORD_LEN;
   localparam int unsigned DEF_ADDR_LEN = `RA_LEN;

   typedef enum logic [1:0] {
      WSRC_NONE = 2'd0,
      WSRC_A    = 2'd1,
      WSRC_B    = 2'd2
   } wsrc_e;

   // Port B wins when both ports target the same register.
   function automatic wsrc_e pick_src(input logic hit_a, input logic hit_b);
      if (hit_b)      return WSRC_B;
      else if (hit_a) return WSRC_A;
      else            return WSRC_NONE;
   endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending (busy) bits: a write clears, busy_set sets, set wins.
// Register 0 is never marked busy.
module rf_scoreboard
   import regfile_mp_pkg::*;
#(
   parameter int unsigned ADDR_LEN = DEF_ADDR_LEN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set,
   input  logic [ADDR_LEN-1:0] set_wa,
   input  logic                clr_a,
   input  logic [ADDR_LEN-1:0] clr_wa_a,
   input  logic                clr_b,
   input  logic [ADDR_LEN-1:0] clr_wa_b,
   input  logic [ADDR_LEN-1:0] ra1,
   input  logic [ADDR_LEN-1:0] ra2,
   output logic                busy1,
   output logic                busy2
);

   localparam int unsigned NREG = 2**ADDR_LEN;

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;

   always_comb begin
      busy_nxt = busy;
      if (clr_a) busy_nxt[clr_wa_a] = 1'b0;
      if (clr_b) busy_nxt[clr_wa_b] = 1'b0;
      if (set)   busy_nxt[set_wa]   = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   assign busy1 = busy[ra1];
   assign busy2 = busy[ra2];

endmodule

// File: rtl/regfile_mp.sv
// Two-read / two-write register file with load scoreboard; register 0 is hardwired 0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy status to the read ports.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int unsigned WORD_LEN = DEF_WORD_LEN,
   parameter int unsigned ADDR_LEN = DEF_ADDR_LEN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_LEN-1:0] ra1,
   input  logic [ADDR_LEN-1:0] ra2,
   output logic [WORD_LEN-1:0] rd1,
   output logic [WORD_LEN-1:0] rd2,
   input  logic                we_a,
   input  logic                we_b,
   input  logic [ADDR_LEN-1:0] wa_a,
   input  logic [ADDR_LEN-1:0] wa_b,
   input  logic [WORD_LEN-1:0] wd_a,
   input  logic [WORD_LEN-1:0] wd_b,
   input  logic                busy_set,
   input  logic [ADDR_LEN-1:0] busy_wa,
   output logic                busy1,
   output logic                busy2
);

   localparam int unsigned NREG = 2**ADDR_LEN;

   logic [WORD_LEN-1:0] regs [NREG];
   logic                wen_a, wen_b;
   logic [WORD_LEN-1:0] rd_st1, rd_st2;
   logic                sb_busy1, sb_busy2;

   assign wen_a = we_a && (wa_a != '0);
   assign wen_b = we_b && (wa_b != '0);

   // Port B is applied after port A so it wins an address collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) regs[ADDR_LEN'(i)] <= '0;
      end else begin
         if (wen_a) regs[wa_a] <= wd_a;
         if (wen_b) regs[wa_b] <= wd_b;
      end
   end

   assign rd_st1 = (ra1 == '0) ? '0 : regs[ra1];
   assign rd_st2 = (ra2 == '0) ? '0 : regs[ra2];

   rf_scoreboard #(
      .ADDR_LEN (ADDR_LEN)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set      (busy_set),
      .set_wa   (busy_wa),
      .clr_a    (we_a),
      .clr_wa_a (wa_a),
      .clr_b    (we_b),
      .clr_wa_b (wa_b),
      .ra1      (ra1),
      .ra2      (ra2),
      .busy1    (sb_busy1),
      .busy2    (sb_busy2)
   );

`ifdef REGFILE_BYPASS_EN
   wsrc_e src1, src2;

   // A forwarded register shows the busy state it will hold after this edge.
   always_comb begin
      src1  = WSRC_NONE;
      src2  = WSRC_NONE;
      rd1   = rd_st1;
      rd2   = rd_st2;
      busy1 = sb_busy1;
      busy2 = sb_busy2;
      if (!rst) begin
         src1 = pick_src(wen_a && (wa_a == ra1), wen_b && (wa_b == ra1));
         src2 = pick_src(wen_a && (wa_a == ra2), wen_b && (wa_b == ra2));
      end
      case (src1)
         WSRC_A:  rd1 = wd_a;
         WSRC_B:  rd1 = wd_b;
         default: ;
      endcase
      case (src2)
         WSRC_A:  rd2 = wd_a;
         WSRC_B:  rd2 = wd_b;
         default: ;
      endcase
      if (src1 != WSRC_NONE) busy1 = busy_set && (busy_wa == ra1);
      if (src2 != WSRC_NONE) busy2 = busy_set && (busy_wa == ra2);
   end
`else
   assign rd1   = rd_st1;
   assign rd2   = rd_st2;
   assign busy1 = sb_busy1;
   assign busy2 = sb_busy2;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed literal checks plus randomized traffic
// compared every cycle against a behavioural array model.
module tb_regfile_mp;

   localparam int unsigned WL = 32;
   localparam int unsigned AL = 5;
   localparam int unsigned NR = 32;

   logic          clk;
   logic          rst;
   logic [AL-1:0] ra1, ra2;
   logic [WL-1:0] rd1, rd2;
   logic          we_a, we_b;
   logic [AL-1:0] wa_a, wa_b;
   logic [WL-1:0] wd_a, wd_b;
   logic          busy_set;
   logic [AL-1:0] busy_wa;
   logic          busy1, busy2;

   int tests = 0;
   int fails = 0;

   regfile_mp #(
      .WORD_LEN (WL),
      .ADDR_LEN (AL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ra1      (ra1),
      .ra2      (ra2),
      .rd1      (rd1),
      .rd2      (rd2),
      .we_a     (we_a),
      .we_b     (we_b),
      .wa_a     (wa_a),
      .wa_b     (wa_b),
      .wd_a     (wd_a),
      .wd_b     (wd_b),
      .busy_set (busy_set),
      .busy_wa  (busy_wa),
      .busy1    (busy1),
      .busy2    (busy2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: stored contents and pending flags, indexed by register number.
   logic [WL-1:0] mem [NR];
   bit            pend [NR];
   bit            model_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NR; i++) begin
            mem[i]  = '0;
            pend[i] = 1'b0;
         end
         model_valid = 1'b1;
      end else begin
         if (we_a && wa_a != 0) begin mem[wa_a] = wd_a; pend[wa_a] = 1'b0; end
         if (we_b && wa_b != 0) begin mem[wa_b] = wd_b; pend[wa_b] = 1'b0; end
         if (busy_set && busy_wa != 0) pend[busy_wa] = 1'b1;
      end
   end

   function automatic logic [WL-1:0] exp_rd(input logic [AL-1:0] ra);
      if (ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (!rst && we_b && wa_b == ra) return wd_b;
      if (!rst && we_a && wa_a == ra) return wd_a;
`endif
      return mem[ra];
   endfunction

   function automatic logic exp_busy(input logic [AL-1:0] ra);
      if (ra == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (!rst && ((we_a && wa_a == ra) || (we_b && wa_b == ra)))
         return busy_set && busy_wa == ra;
`endif
      return pend[ra];
   endfunction

   task automatic check(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_valid) begin
         check("model_rd1",   rd1, exp_rd(ra1));
         check("model_rd2",   rd2, exp_rd(ra2));
         check("model_busy1", {31'd0, busy1}, {31'd0, exp_busy(ra1)});
         check("model_busy2", {31'd0, busy2}, {31'd0, exp_busy(ra2)});
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      rst = 1'b0; we_a = 1'b0; we_b = 1'b0; busy_set = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ra1 = '0; ra2 = '0;
      we_a = 1'b0; we_b = 1'b0; wa_a = '0; wa_b = '0; wd_a = '0; wd_b = '0;
      busy_set = 1'b0; busy_wa = '0;
      tick;
      idle;

      // Reset state
      ra1 = 5'd0; ra2 = 5'd5; #2;
      check("rst_rd_0", rd1, 32'h0);
      check("rst_rd_5", rd2, 32'h0);
      check("rst_busy", {30'd0, busy1, busy2}, 32'h0);
      ra1 = 5'd31; #1;
      check("rst_rd_31", rd1, 32'h0);
      check("rst_busy_31", {31'd0, busy1}, 32'h0);

      // Basic writes on both ports
      we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hA5A5A5A5; ra1 = 5'd5;
      tick; idle; #2;
      check("wr_a_5", rd1, 32'hA5A5A5A5);
      we_b = 1'b1; wa_b = 5'd3; wd_b = 32'h3C3C3C3C;
      tick; idle; ra1 = 5'd3; ra2 = 5'd5; #2;
      check("wr_b_3", rd1, 32'h3C3C3C3C);
      check("keep_5", rd2, 32'hA5A5A5A5);

      // Collision and register 0
      we_a = 1'b1; we_b = 1'b1; wa_a = 5'd7; wa_b = 5'd7;
      wd_a = 32'h11111111; wd_b = 32'h22222222;
      tick; idle; ra1 = 5'd7; #2;
      check("collide_b_wins", rd1, 32'h22222222);
      we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
      tick; idle; #2;
      check("reg0_zero", rd1, 32'h0);

      // Scoreboard set / clear / set-wins
      busy_set = 1'b1; busy_wa = 5'd9;
      tick; idle; ra1 = 5'd9; #2;
      check("busy_set_9", {31'd0, busy1}, 32'd1);
      we_a = 1'b1; wa_a = 5'd9; wd_a = 32'hDEADBEEF;
      tick; idle; #2;
      check("busy_clr_9", {31'd0, busy1}, 32'd0);
      check("rd_9", rd1, 32'hDEADBEEF);
      busy_set = 1'b1; busy_wa = 5'd9; we_b = 1'b1; wa_b = 5'd9; wd_b = 32'h99;
      tick; idle; #2;
      check("busy_set_wins", {31'd0, busy1}, 32'd1);
      busy_set = 1'b1; busy_wa = 5'd0; ra2 = 5'd0;
      tick; idle; #2;
      check("busy_reg0", {31'd0, busy2}, 32'd0);

      // Same-cycle read of a register being written
      ra1 = 5'd12; we_a = 1'b1; wa_a = 5'd12; wd_a = 32'hCAFEF00D; #2;
`ifdef REGFILE_BYPASS_EN
      check("bypass_rd", rd1, 32'hCAFEF00D);
`else
      check("no_bypass_rd", rd1, 32'h0);
`endif
      tick; idle; #2;
      check("after_edge_12", rd1, 32'hCAFEF00D);

      // Reset overrides a same-cycle write and busy_set
      we_a = 1'b1; wa_a = 5'd4; wd_a = 32'h12345678; busy_set = 1'b1; busy_wa = 5'd4;
      tick; idle; ra1 = 5'd4; #2;
      check("pre_rst_4", rd1, 32'h12345678);
      rst = 1'b1; we_a = 1'b1; wa_a = 5'd4; wd_a = 32'h87654321; #2;
      check("rst_no_bypass", rd1, 32'h12345678);
      tick; idle; #2;
      check("rst_rd_4", rd1, 32'h0);
      check("rst_busy_4", {31'd0, busy1}, 32'd0);

      // Randomized traffic, addresses biased low to provoke collisions
      for (int n = 0; n < 3000; n++) begin
         rst      = ($urandom_range(0, 99) == 0);
         we_a     = $urandom_range(0, 1);
         we_b     = $urandom_range(0, 1);
         busy_set = $urandom_range(0, 2) == 0;
         wa_a     = $urandom_range(0, 1) ? AL'($urandom_range(0, 3)) : AL'($urandom);
         wa_b     = $urandom_range(0, 1) ? AL'($urandom_range(0, 3)) : AL'($urandom);
         busy_wa  = $urandom_range(0, 1) ? AL'($urandom_range(0, 3)) : AL'($urandom);
         ra1      = $urandom_range(0, 1) ? AL'($urandom_range(0, 3)) : AL'($urandom);
         ra2      = $urandom_range(0, 1) ? AL'($urandom_range(0, 3)) : AL'($urandom);
         wd_a     = $urandom;
         wd_b     = $urandom;
         tick;
      end

      idle;
      tick;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
